// File: rtl/ni_ctrl.sv
// Processor-side NoC interface controller for the decode stage.
// Buffers outbound words in a FIFO; stalls decode on a blocking receive.
module ni_ctrl #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int RX_TIMEOUT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ni_out_D,
  input  logic              ni_in_D,
  input  logic [ADDR_W-1:0] dest_add_D,
  input  logic [DATA_W-1:0] tx_data_D,
  input  logic [4:0]        rd_D,
  output logic              stall,
  input  logic              mips_ni,
  output logic              proc_valid,
  output logic [ADDR_W-1:0] proc_dest,
  output logic [DATA_W-1:0] proc_data,
  input  logic              data_valid,
  input  logic [DATA_W-1:0] ni_data,
  output logic              proc_ready_in,
  output logic              rx_we,
  output logic [4:0]        rx_rd,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_timeout
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = ADDR_W + DATA_W;
  localparam int TW = (RX_TIMEOUT < 2) ? 1 : $clog2(RX_TIMEOUT);
  localparam logic [TW-1:0] T_LAST =
    TW'((RX_TIMEOUT >= 2) ? RX_TIMEOUT - 2 : 0);

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_WAIT,
    RX_WB
  } rx_state_t;

  logic [EW-1:0]     mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic [EW-1:0]     head;

  rx_state_t         state;
  logic [TW-1:0]     timer;
  logic [4:0]        rd_q;
  logic [DATA_W-1:0] data_q;
  logic              tmo_q;
  logic              rx_stall;
  logic              tmo_hit;

  assign full     = (count == CW'(FIFO_DEPTH));
  assign empty    = (count == '0);
  assign rx_stall = ((state == RX_IDLE) && ni_in_D) ||
                    (state == RX_WAIT);
  assign push     = ni_out_D && !ni_in_D && !full && !rx_stall;
  assign pop      = !empty && mips_ni;
  assign head     = mem[rd_ptr];

  // Timer reaches RX_TIMEOUT-1 on this increment
  assign tmo_hit  = (RX_TIMEOUT != 0) &&
                    ((RX_TIMEOUT == 1) || (timer == T_LAST));

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {dest_add_D, tx_data_D};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= RX_IDLE;
      timer  <= '0;
      rd_q   <= '0;
      data_q <= '0;
      tmo_q  <= 1'b0;
    end else begin
      unique case (state)
        RX_IDLE: begin
          if (ni_in_D) begin
            timer <= '0;
            if (data_valid) begin
              state  <= RX_WB;
              rd_q   <= rd_D;
              data_q <= ni_data;
              tmo_q  <= 1'b0;
            end else begin
              state <= RX_WAIT;
            end
          end
        end
        RX_WAIT: begin
          if (data_valid) begin
            state  <= RX_WB;
            rd_q   <= rd_D;
            data_q <= ni_data;
            tmo_q  <= 1'b0;
            timer  <= '0;
          end else if (tmo_hit) begin
            state  <= RX_WB;
            rd_q   <= rd_D;
            data_q <= '0;
            tmo_q  <= 1'b1;
            timer  <= '0;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        RX_WB: begin
          state <= RX_IDLE;
          tmo_q <= 1'b0;
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

  // Every output is forced low for as long as reset is held
  assign stall         = !rst && (rx_stall || (ni_out_D && full));
  assign proc_valid    = !rst && !empty;
  assign proc_dest     = (rst || empty) ? '0 : head[EW-1:DATA_W];
  assign proc_data     = (rst || empty) ? '0 : head[DATA_W-1:0];
  assign proc_ready_in = !rst && rx_stall;
  assign rx_we         = !rst && (state == RX_WB);
  assign rx_rd         = rst ? '0 : rd_q;
  assign rx_data       = rst ? '0 : data_q;
  assign rx_timeout    = !rst && (state == RX_WB) && tmo_q;

endmodule

// File: tb/tb_ni_ctrl.sv
// Bench for ni_ctrl: directed plan plus random traffic
// against a queue-based reference model.
module tb_ni_ctrl;

  localparam int DW = 32;
  localparam int AW = 2;
  localparam int D  = 4;
  localparam int T  = 8;

  typedef logic [AW+DW-1:0] ent_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          ni_out, ni_in, mips_ni, dv;
  logic [AW-1:0] dest;
  logic [DW-1:0] txd, nid;
  logic [4:0]    rd;
  logic          stall, pv, pready, we, tmo;
  logic [AW-1:0] pd;
  logic [DW-1:0] pdat, rdat;
  logic [4:0]    rrd;

  logic          ni_out0, ni_in0, mips0, dv0;
  logic          stall0, pv0, pready0, we0, tmo0;
  logic [AW-1:0] pd0;
  logic [DW-1:0] pdat0, rdat0;
  logic [4:0]    rrd0;

  ni_ctrl #(.DATA_W(DW), .ADDR_W(AW), .FIFO_DEPTH(D),
            .RX_TIMEOUT(T)) u8 (
    .clk(clk), .rst(rst),
    .ni_out_D(ni_out), .ni_in_D(ni_in),
    .dest_add_D(dest), .tx_data_D(txd), .rd_D(rd),
    .stall(stall), .mips_ni(mips_ni),
    .proc_valid(pv), .proc_dest(pd), .proc_data(pdat),
    .data_valid(dv), .ni_data(nid),
    .proc_ready_in(pready), .rx_we(we), .rx_rd(rrd),
    .rx_data(rdat), .rx_timeout(tmo)
  );

  ni_ctrl #(.DATA_W(DW), .ADDR_W(AW), .FIFO_DEPTH(D),
            .RX_TIMEOUT(0)) u0 (
    .clk(clk), .rst(rst),
    .ni_out_D(ni_out0), .ni_in_D(ni_in0),
    .dest_add_D(dest), .tx_data_D(txd), .rd_D(rd),
    .stall(stall0), .mips_ni(mips0),
    .proc_valid(pv0), .proc_dest(pd0), .proc_data(pdat0),
    .data_valid(dv0), .ni_data(nid),
    .proc_ready_in(pready0), .rx_we(we0), .rx_rd(rrd0),
    .rx_data(rdat0), .rx_timeout(tmo0)
  );

  int tests = 0;
  int fails = 0;

  ent_t          q[$];
  bit            m_wb, m_tmo;
  logic [4:0]    m_rd;
  logic [DW-1:0] m_data;
  int            m_n;
  bit            e_stall, e_cap;
  logic          o_stall;

  task automatic check(string tag, logic [63:0] got,
                       logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock of the timeout-8 instance against the model
  task automatic cyc();
    bit            full, rxs, psh;
    ent_t          h;
    @(negedge clk);
    o_stall = stall;
    full = (q.size() == D);
    rxs  = !m_wb && (ni_in || m_n > 0);
    if (rst) begin
      e_stall = 0;
      e_cap   = 0;
      check("rst_stall", stall, 0);
      check("rst_pv", pv, 0);
      check("rst_pd", pd, 0);
      check("rst_pdat", pdat, 0);
      check("rst_ready", pready, 0);
      check("rst_we", we, 0);
      check("rst_rrd", rrd, 0);
      check("rst_rdat", rdat, 0);
      check("rst_tmo", tmo, 0);
    end else begin
      e_stall = rxs || (ni_out && full);
      e_cap   = rxs && dv;
      h = (q.size() != 0) ? q[0] : '0;
      check("stall", stall, e_stall);
      check("proc_valid", pv, q.size() != 0);
      check("proc_dest", pd, h[AW+DW-1:DW]);
      check("proc_data", pdat, h[DW-1:0]);
      check("ready_in", pready, rxs);
      check("rx_we", we, m_wb);
      check("rx_timeout", tmo, m_wb && m_tmo);
      if (m_wb) begin
        check("rx_rd", rrd, m_rd);
        check("rx_data", rdat, m_data);
      end
    end
    @(posedge clk);
    if (rst) begin
      q.delete();
      m_wb = 0;
      m_n  = 0;
    end else begin
      psh = ni_out && !ni_in && !full && !rxs;
      if (q.size() != 0 && mips_ni) void'(q.pop_front());
      if (psh) q.push_back({dest, txd});
      if (m_wb) begin
        m_wb = 0;
      end else if (rxs) begin
        m_n++;
        if (dv) begin
          m_wb = 1; m_tmo = 0; m_rd = rd; m_data = nid; m_n = 0;
        end else if (T != 0 && m_n == T) begin
          m_wb = 1; m_tmo = 1; m_rd = rd; m_data = '0; m_n = 0;
        end
      end
    end
    #1;
  endtask

  task automatic new_instr();
    int k;
    k = $urandom_range(0, 15);
    ni_out = (k >= 3 && k <= 9) || k == 15;
    ni_in  = (k >= 10);
    dest   = AW'($urandom);
    txd    = $urandom;
    rd     = 5'($urandom);
  endtask

  initial begin
    int cnt;
    rst = 1; ni_out = 0; ni_in = 0; mips_ni = 0; dv = 0;
    dest = 0; txd = 0; nid = 0; rd = 0;
    ni_out0 = 0; ni_in0 = 0; mips0 = 0; dv0 = 0;
    m_wb = 0; m_tmo = 0; m_rd = 0; m_data = 0; m_n = 0;
    cyc();
    cyc();
    rst = 0;
    cyc();

    // Three sends drained in order
    mips_ni = 1;
    for (int i = 0; i < 3; i++) begin
      ni_out = 1; dest = AW'(i + 1); txd = DW'(32'hA + i);
      cyc();
    end
    ni_out = 0;
    repeat (4) cyc();

    // Five sends into a 4-deep FIFO with the NI blocked
    mips_ni = 0;
    for (int i = 0; i < 5; i++) begin
      ni_out = 1; dest = AW'(i); txd = DW'(32'h100 + i);
      cyc();
    end
    check("fifth_stall", stall, 1);
    mips_ni = 1;
    cyc();
    mips_ni = 0;
    cyc();
    ni_out = 0;
    mips_ni = 1;
    repeat (6) cyc();

    // Receive with data already present
    ni_in = 1; rd = 7; dv = 1; nid = 32'h1234;
    cyc();
    check("rx_we_now", we, 1);
    check("rx_rd_now", rrd, 7);
    check("rx_data_now", rdat, 32'h1234);
    dv = 0;
    cyc();
    ni_in = 0;
    cyc();

    // Receive with data delayed five cycles
    ni_in = 1; rd = 12; nid = 32'hCAFE;
    repeat (5) cyc();
    dv = 1;
    cyc();
    dv = 0;
    cyc();
    ni_in = 0;
    cyc();

    // Timeout after eight stall cycles
    ni_in = 1; rd = 3; cnt = 0;
    for (int g = 0; g < 20; g++) begin
      cyc();
      if (o_stall) cnt++;
      if (!e_stall) break;
    end
    check("tmo_stalls", cnt, T);
    ni_in = 0;
    cyc();

    // Timeout disabled: long wait, then capture
    ni_in0 = 1; rd = 9; nid = 32'h55;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("u0_wait_stall", stall0, 1);
      check("u0_wait_tmo", tmo0, 0);
      check("u0_wait_we", we0, 0);
      @(posedge clk); #1;
    end
    dv0 = 1;
    @(negedge clk);
    check("u0_cap_ready", pready0, 1);
    @(posedge clk); #1;
    dv0 = 0;
    @(negedge clk);
    check("u0_we", we0, 1);
    check("u0_rd", rrd0, 9);
    check("u0_data", rdat0, 32'h55);
    check("u0_stall", stall0, 0);
    check("u0_fifo", {pv0, pd0, pdat0}, 0);
    @(posedge clk); #1;
    ni_in0 = 0;
    @(negedge clk);
    check("u0_idle", {stall0, we0, tmo0}, 0);
    @(posedge clk); #1;

    // Reset while waiting with a non-empty FIFO
    mips_ni = 0;
    ni_out = 1; dest = 2; txd = 32'h77;
    cyc();
    ni_out = 1; dest = 1; txd = 32'h78;
    cyc();
    ni_out = 0; ni_in = 1; rd = 5;
    repeat (3) cyc();
    rst = 1;
    cyc();
    rst = 0; ni_in = 0;
    cyc();
    check("post_rst_pv", pv, 0);
    check("post_rst_we", we, 0);
    ni_in = 1; rd = 4; dv = 1; nid = 32'hBEEF;
    cyc();
    dv = 0;
    cyc();
    ni_in = 0;
    cyc();

    // Random traffic
    new_instr();
    for (int c = 0; c < 3000; c++) begin
      cyc();
      if (e_cap) dv = 0;
      if (!dv && $urandom_range(0, 4) == 0) begin
        dv  = 1;
        nid = $urandom;
      end
      mips_ni = 1'($urandom_range(0, 1));
      if (!e_stall) new_instr();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
